// File: rtl/shift_issue_reg.sv
// Decode-to-shifter pipeline register: captures one shift per handshake and forwards rs1/rs2.
// Optional performance counters are enabled with `define SHIFT_ISSUE_PERF_EN.
module shift_issue_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_imm_shamt,
  input  logic        in_use_imm,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_in,
  output logic [4:0]  out_shamt,
  output logic [1:0]  out_alu,
  output logic [4:0]  out_rd,
  output logic        out_illegal
`ifdef SHIFT_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  logic        valid_reg;
  logic [31:0] in_reg;
  logic [4:0]  shamt_reg;
  logic [1:0]  alu_reg;
  logic [4:0]  rd_reg;
  logic        illegal_reg;

  logic        load;
  logic [1:0]  alu_next;
  logic        illegal_next;
  logic [4:0]  shamt_next;

  logic [4:0]  src_addr [2];
  logic [31:0] src_rf   [2];
  logic [31:0] src_fwd  [2];
  logic        unused_rs2_hi;

  assign src_addr[0] = in_rs1_addr;
  assign src_addr[1] = in_rs2_addr;
  assign src_rf[0]   = in_rs1_data;
  assign src_rf[1]   = in_rs2_data;

  // EX/MEM result is younger than MEM/WB, so it wins when both target the same register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        src_fwd[gi] = src_rf[gi];
        if (src_addr[gi] == 5'd0)
          src_fwd[gi] = 32'd0;
        else if (mem_wr_en && (mem_rd_addr == src_addr[gi]))
          src_fwd[gi] = mem_rd_data;
        else if (wb_wr_en && (wb_rd_addr == src_addr[gi]))
          src_fwd[gi] = wb_rd_data;
      end
    end
  endgenerate

  // Only the low five bits of rs2 form a shift amount.
  assign unused_rs2_hi = ^src_fwd[1][31:5];
  assign shamt_next    = in_use_imm ? in_imm_shamt : src_fwd[1][4:0];

  always_comb begin
    alu_next     = 2'b11;
    illegal_next = 1'b1;
    if ((in_funct3 == 3'b001) && !in_funct7b5) begin
      alu_next     = 2'b00;
      illegal_next = 1'b0;
    end else if (in_funct3 == 3'b101) begin
      alu_next     = in_funct7b5 ? 2'b01 : 2'b10;
      illegal_next = 1'b0;
    end
  end

  assign in_ready = !valid_reg || out_ready || flush;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      in_reg      <= 32'd0;
      shamt_reg   <= 5'd0;
      alu_reg     <= 2'b11;
      rd_reg      <= 5'd0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg   <= 1'b1;
      in_reg      <= src_fwd[0];
      shamt_reg   <= shamt_next;
      alu_reg     <= alu_next;
      rd_reg      <= in_rd_addr;
      illegal_reg <= illegal_next;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_in      = in_reg;
  assign out_shamt   = shamt_reg;
  assign out_alu     = alu_reg;
  assign out_rd      = rd_reg;
  assign out_illegal = illegal_reg;

`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] issued_reg;
  logic [31:0] stall_reg;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_reg <= 32'd0;
      stall_reg  <= 32'd0;
    end else begin
      if (load && (issued_reg != 32'hFFFF_FFFF))
        issued_reg <= issued_reg + 32'd1;
      if (valid_reg && !out_ready && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign perf_issued = issued_reg;
  assign perf_stall  = stall_reg;
`endif

endmodule

// File: tb/tb_shift_issue_reg.sv
// Scoreboard bench for shift_issue_reg: driver pushes expected entries, monitor checks held outputs.
// Perf counter checks are compiled in when SHIFT_ISSUE_PERF_EN is defined.
module tb_shift_issue_reg;

  typedef struct {
    logic        flush, in_valid, out_ready;
    logic [4:0]  rs1a, rs2a, rda, imm;
    logic [31:0] rs1d, rs2d;
    logic        use_imm;
    logic [2:0]  f3;
    logic        f7;
    logic        mem_en, wb_en;
    logic [4:0]  mem_a, wb_a;
    logic [31:0] mem_d, wb_d;
  } stim_t;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  shamt;
    logic [1:0]  alu;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm_shamt;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic        in_use_imm, in_funct7b5;
  logic [2:0]  in_funct3;
  logic        mem_wr_en, wb_wr_en;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_rd_data, wb_rd_data;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_in;
  logic [4:0]  out_shamt, out_rd;
  logic [1:0]  out_alu;
`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic model_valid = 1'b0;
  logic mon_en = 1'b0;
  int   exp_issued = 0;
  int   exp_stall = 0;

  shift_issue_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm_shamt(in_imm_shamt), .in_use_imm(in_use_imm),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in(out_in), .out_shamt(out_shamt), .out_alu(out_alu),
    .out_rd(out_rd), .out_illegal(out_illegal)
`ifdef SHIFT_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: operand lookup with x0 hardwired and the newest producer first.
  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf, input stim_t s);
    if (a == 0) return 32'd0;
    if (s.mem_en && s.mem_a == a) return s.mem_d;
    if (s.wb_en && s.wb_a == a) return s.wb_d;
    return rf;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t        e;
    logic [31:0] r2;
    e.val   = resolve(s.rs1a, s.rs1d, s);
    r2      = resolve(s.rs2a, s.rs2d, s);
    e.shamt = s.use_imm ? s.imm : r2[4:0];
    e.rd    = s.rda;
    e.ill   = 1'b0;
    case ({s.f3, s.f7})
      4'b0010: e.alu = 2'b00;   // SLL
      4'b1011: e.alu = 2'b01;   // SRA
      4'b1010: e.alu = 2'b10;   // SRL
      default: begin e.alu = 2'b11; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.flush     = ($urandom_range(0, 9) == 0);
    s.in_valid  = ($urandom_range(0, 3) != 0);
    s.out_ready = ($urandom_range(0, 9) < 7);
    s.rs1a  = 5'($urandom_range(0, 3));
    s.rs2a  = 5'($urandom_range(0, 3));
    s.rda   = 5'($urandom);
    s.imm   = 5'($urandom);
    s.rs1d  = $urandom;
    s.rs2d  = $urandom;
    s.use_imm = 1'($urandom);
    s.f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101);
    s.f7    = 1'($urandom);
    s.mem_en = 1'($urandom);
    s.wb_en  = 1'($urandom);
    s.mem_a = 5'($urandom_range(0, 3));
    s.wb_a  = 5'($urandom_range(0, 3));
    s.mem_d = $urandom;
    s.wb_d  = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    flush = s.flush; in_valid = s.in_valid; out_ready = s.out_ready;
    in_rs1_addr = s.rs1a; in_rs2_addr = s.rs2a; in_rd_addr = s.rda;
    in_rs1_data = s.rs1d; in_rs2_data = s.rs2d; in_imm_shamt = s.imm;
    in_use_imm = s.use_imm; in_funct3 = s.f3; in_funct7b5 = s.f7;
    mem_wr_en = s.mem_en; mem_rd_addr = s.mem_a; mem_rd_data = s.mem_d;
    wb_wr_en = s.wb_en; wb_rd_addr = s.wb_a; wb_rd_data = s.wb_d;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply(input stim_t s);
    logic rdy, ld;
    drive(s);
    rdy = !model_valid || s.out_ready || s.flush;
    #1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    ld = s.in_valid && rdy && !s.flush;
    if (model_valid && !s.out_ready) exp_stall++;
    @(posedge clk);
    if (ld) begin
      sb_q.push_back(expect_of(s));
      exp_issued++;
    end
    if (s.flush) model_valid = 1'b0;
    else if (ld) model_valid = 1'b1;
    else if (s.out_ready) model_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    stim_t s;
    mon_en = 1'b0;
    s = rand_stim();
    s.in_valid = 1'b1;
    drive(s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    model_valid = 1'b0;
    exp_issued = 0;
    exp_stall = 0;
    drive(idle());
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_in", out_in, 32'd0);
    chk("rst out_shamt", 32'(out_shamt), 32'd0);
    chk("rst out_alu", 32'(out_alu), 32'd3);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_illegal", 32'(out_illegal), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Monitor: the front of the scoreboard is whatever the DUT must be holding right now.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (sb_q.size() > 0) begin
          chk("out_valid", 32'(out_valid), 32'd1);
          chk("out_in", out_in, sb_q[0].val);
          chk("out_shamt", 32'(out_shamt), 32'(sb_q[0].shamt));
          chk("out_alu", 32'(out_alu), 32'(sb_q[0].alu));
          chk("out_rd", 32'(out_rd), 32'(sb_q[0].rd));
          chk("out_illegal", 32'(out_illegal), 32'(sb_q[0].ill));
          if (out_ready || flush) begin
            $display("entry rd=%0d in=%h shamt=%0d alu=%b ill=%b %s", sb_q[0].rd, sb_q[0].val,
                     sb_q[0].shamt, sb_q[0].alu, sb_q[0].ill, flush ? "squashed" : "issued");
            void'(sb_q.pop_front());
          end
        end else begin
          chk("out_valid idle", 32'(out_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    stim_t s, a, b;
    rst = 1'b1;
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // SRAI by immediate
    s = idle(); s.in_valid = 1; s.rs1a = 1; s.rs1d = 32'h8000_00F0;
    s.f3 = 3'b101; s.f7 = 1; s.use_imm = 1; s.imm = 4; s.rda = 7;
    apply(s);
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 out_in", out_in, 32'h8000_00F0);
    chk("t1 out_shamt", 32'(out_shamt), 32'd4);
    chk("t1 out_alu", 32'(out_alu), 32'd1);
    chk("t1 out_illegal", 32'(out_illegal), 32'd0);

    // SLL by register, upper rs2 bits ignored
    s = idle(); s.in_valid = 1; s.rs1a = 3; s.rs1d = 32'h0000_0001;
    s.rs2a = 2; s.rs2d = 32'hFFFF_FFE3; s.f3 = 3'b001; s.rda = 9;
    apply(s);
    chk("t2 out_shamt", 32'(out_shamt), 32'd3);
    chk("t2 out_alu", 32'(out_alu), 32'd0);

    // forwarding priority and x0
    s = idle(); s.in_valid = 1; s.rs1a = 5; s.rs1d = 32'h3333_3333; s.f3 = 3'b101;
    s.mem_en = 1; s.mem_a = 5; s.mem_d = 32'h1111_1111;
    s.wb_en = 1; s.wb_a = 5; s.wb_d = 32'h2222_2222;
    apply(s);
    chk("t3 mem fwd", out_in, 32'h1111_1111);
    s.rs1a = 0; s.mem_a = 0; s.wb_a = 0;
    apply(s);
    chk("t3 x0", out_in, 32'd0);

    // stall: A held three cycles while B is offered
    do_reset();
    a = idle(); a.in_valid = 1; a.rs1a = 1; a.rs1d = 32'hAAAA_0001; a.f3 = 3'b101; a.use_imm = 1; a.imm = 1; a.rda = 1;
    b = idle(); b.in_valid = 1; b.rs1a = 2; b.rs1d = 32'hBBBB_0002; b.f3 = 3'b001; b.use_imm = 1; b.imm = 2; b.rda = 2;
    apply(a);
    b.out_ready = 0;
    repeat (3) begin
      apply(b);
      chk("t4 hold in", out_in, 32'hAAAA_0001);
    end
    b.out_ready = 1;
    apply(b);
    chk("t4 B in", out_in, 32'hBBBB_0002);
    chk("t4 B rd", 32'(out_rd), 32'd2);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("t4 perf_stall", perf_stall, 32'd3);
    chk("t4 perf_issued", perf_issued, 32'd2);
`endif

    // flush while holding B and offering C
    s = idle(); s.flush = 1; s.in_valid = 1; s.out_ready = 0;
    s.rs1a = 4; s.rs1d = 32'hCCCC_CCCC; s.f3 = 3'b101; s.rda = 12;
    apply(s);
    chk("t5 out_valid", 32'(out_valid), 32'd0);
    s = idle(); s.out_ready = 0;
    apply(s);
    chk("t5 still empty", 32'(out_valid), 32'd0);

    // illegal encoding flows through, then reset mid-hold
    s = idle(); s.in_valid = 1; s.rs1a = 6; s.rs1d = 32'h1234_5678; s.f3 = 3'b000; s.rda = 3;
    apply(s);
    chk("t6 out_valid", 32'(out_valid), 32'd1);
    chk("t6 out_alu", 32'(out_alu), 32'd3);
    chk("t6 out_illegal", 32'(out_illegal), 32'd1);
    s = idle(); s.out_ready = 0;
    apply(s);
    do_reset();

    for (int i = 0; i < 2000; i++) apply(rand_stim());
`ifdef SHIFT_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, 32'(exp_issued));
    chk("perf_stall", perf_stall, 32'(exp_stall));
`endif
    s = idle();
    apply(s);
    apply(s);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
